digit_serial_adder: RTL and testbench



---
 rtl/digit_serial_adder_pkg.sv | 22 ++
 rtl/digit_adder.sv | 23 ++
 rtl/digit_serial_adder.sv | 105 ++++++++++
 tb/tb_digit_serial_adder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package adder_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
      return width / digit;
   endfunction

   // Counter width for n digits, never narrower than one bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((longint'(1) << w) < longint'(n)) w++;
      return w;
   endfunction

   function automatic bit legal_cfg(input int unsigned width, input int unsigned digit);
      return (width >= 1) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
   endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit adder slice with carry-out and carry into its top bit.
module digit_adder
   import adder_pkg::*;
#(
   parameter int unsigned DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             cmsb
);

   logic [DIGIT:0] total;

   assign total = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, ci};
   assign s     = total[DIGIT-1:0];
   assign co    = total[DIGIT];
   // Carry into the top bit is recovered from that bit's sum and operands.
   assign cmsb  = a[DIGIT-1] ^ b[DIGIT-1] ^ s[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial two's-complement adder/subtractor: one operand pair per
// transaction, DIGIT bits rippled per clock, LSB digit first.
module digit_serial_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned   NDIG = ndig(WIDTH, DIGIT);
   localparam int unsigned   CW   = clog2(NDIG);
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   if (!legal_cfg(WIDTH, DIGIT)) begin : g_cfg_check
      $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
   end

   state_t                   state;
   logic [CW-1:0]            cnt;
   logic [WIDTH-1:0]         ra;
   logic [WIDTH-1:0]         rb;
   logic                     c;
   logic                     accept;
   logic [DIGIT-1:0]         ds;
   logic                     dco;
   logic                     dcmsb;
   logic [WIDTH+DIGIT-1:0]   sum_cat;

   digit_adder #(.DIGIT(DIGIT)) u_digit (
      .a    (ra[DIGIT-1:0]),
      .b    (rb[DIGIT-1:0]),
      .ci   (c),
      .s    (ds),
      .co   (dco),
      .cmsb (dcmsb)
   );

   assign in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
   assign accept   = in_valid && in_ready;
   // New digit enters at the top; after NDIG shifts the LSB digit sits at bit 0.
   assign sum_cat  = {ds, sum};

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         ra        <= '0;
         rb        <= '0;
         c         <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (accept) begin
            ra  <= a;
            rb  <= b ^ {WIDTH{sub}};
            c   <= cin ^ sub;
            cnt <= '0;
         end else if (state == RUN) begin
            sum <= sum_cat[WIDTH+DIGIT-1:DIGIT];
            ra  <= ra >> DIGIT;
            rb  <= rb >> DIGIT;
            c   <= dco;
            cnt <= cnt + CW'(1);
         end

         case (state)
            IDLE: begin
               if (accept) state <= RUN;
            end
            RUN: begin
               if (cnt == LAST) begin
                  cout      <= dco;
                  ovf       <= dco ^ dcmsb;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= in_valid ? RUN : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: three configurations (8/4, 8/8, 32/1) checked
// every cycle against an arithmetic reference model.
module tb_digit_serial_adder;

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;

   logic        in_valid_i [3];
   logic        out_ready_i[3];
   logic [31:0] a_i        [3];
   logic [31:0] b_i        [3];
   logic        cin_i      [3];
   logic        sub_i      [3];

   logic        in_ready_o [3];
   logic        out_valid_o[3];
   logic [31:0] sum_o      [3];
   logic        cout_o     [3];
   logic        ovf_o      [3];

   logic        rdy0, rdy1, rdy2, vld0, vld1, vld2;
   logic        co0, co1, co2, ov0, ov1, ov2;
   logic [7:0]  sum0, sum1;
   logic [31:0] sum2;

   bit          busy [3];
   res_t        expv [3];
   int unsigned due  [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   digit_serial_adder #(.WIDTH(8), .DIGIT(4)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid_i[0]), .in_ready(rdy0),
      .a(a_i[0][7:0]), .b(b_i[0][7:0]), .cin(cin_i[0]), .sub(sub_i[0]),
      .out_valid(vld0), .out_ready(out_ready_i[0]), .sum(sum0), .cout(co0), .ovf(ov0));

   digit_serial_adder #(.WIDTH(8), .DIGIT(8)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid_i[1]), .in_ready(rdy1),
      .a(a_i[1][7:0]), .b(b_i[1][7:0]), .cin(cin_i[1]), .sub(sub_i[1]),
      .out_valid(vld1), .out_ready(out_ready_i[1]), .sum(sum1), .cout(co1), .ovf(ov1));

   digit_serial_adder #(.WIDTH(32), .DIGIT(1)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid_i[2]), .in_ready(rdy2),
      .a(a_i[2]), .b(b_i[2]), .cin(cin_i[2]), .sub(sub_i[2]),
      .out_valid(vld2), .out_ready(out_ready_i[2]), .sum(sum2), .cout(co2), .ovf(ov2));

   assign in_ready_o[0] = rdy0;  assign in_ready_o[1] = rdy1;  assign in_ready_o[2] = rdy2;
   assign out_valid_o[0] = vld0; assign out_valid_o[1] = vld1; assign out_valid_o[2] = vld2;
   assign sum_o[0] = {24'd0, sum0}; assign sum_o[1] = {24'd0, sum1}; assign sum_o[2] = sum2;
   assign cout_o[0] = co0; assign cout_o[1] = co1; assign cout_o[2] = co2;
   assign ovf_o[0] = ov0;  assign ovf_o[1] = ov1;  assign ovf_o[2] = ov2;

   function automatic int width_of(input int k);
      return (k == 2) ? 32 : 8;
   endfunction

   function automatic int ndig_of(input int k);
      case (k)
         0:       return 2;
         1:       return 1;
         default: return 32;
      endcase
   endfunction

   // Reference: integer arithmetic for the sum/carry, signed range test for overflow.
   function automatic res_t ref_calc(input int w, input logic [31:0] av, input logic [31:0] bv,
                                     input logic ci, input logic s);
      longint span, half, ua, ub, sa, sb, c, full, sres;
      res_t   r;
      span = longint'(1) << w;
      half = longint'(1) << (w - 1);
      ua   = longint'(av) & (span - 1);
      ub   = longint'(bv) & (span - 1);
      sa   = (ua >= half) ? ua - span : ua;
      sb   = (ub >= half) ? ub - span : ub;
      c    = ci ? 1 : 0;
      if (!s) begin
         full = ua + ub + c;
         sres = sa + sb + c;
      end else begin
         full = ua + (span - 1 - ub) + (1 - c);
         sres = sa - sb - c;
      end
      r.sum  = 32'(full & (span - 1));
      r.cout = (full >= span);
      r.ovf  = (sres < -half) || (sres >= half);
      return r;
   endfunction

   task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, k, cyc, got, want);
      end
   endtask

   // Single compare process: predicts handshake and results each cycle.
   initial begin
      for (int k = 0; k < 3; k++) busy[k] = 1'b0;
      forever begin
         @(negedge clk);
         if (cyc > 0) begin
            for (int k = 0; k < 3; k++) begin
               logic exp_vld, exp_rdy;
               exp_vld = busy[k] && (cyc >= due[k]);
               exp_rdy = !rst && (!busy[k] || (exp_vld && out_ready_i[k]));
               check("in_ready", k, 32'(in_ready_o[k]), 32'(exp_rdy));
               check("out_valid", k, 32'(out_valid_o[k]), 32'(exp_vld));
               if (exp_vld && out_valid_o[k]) begin
                  check("sum", k, sum_o[k], expv[k].sum);
                  check("cout", k, 32'(cout_o[k]), 32'(expv[k].cout));
                  check("ovf", k, 32'(ovf_o[k]), 32'(expv[k].ovf));
               end
               if (rst) begin
                  busy[k] = 1'b0;
               end else begin
                  if (exp_vld && out_ready_i[k]) busy[k] = 1'b0;
                  if (in_valid_i[k] && exp_rdy) begin
                     expv[k] = ref_calc(width_of(k), a_i[k], b_i[k], cin_i[k], sub_i[k]);
                     due[k]  = cyc + ndig_of(k) + 1;
                     busy[k] = 1'b1;
                  end
               end
            end
         end
      end
   end

   task automatic do_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                        input logic cv, input logic sv);
      bit ok;
      ok = 1'b0;
      in_valid_i[k] = 1'b1;
      a_i[k] = av; b_i[k] = bv; cin_i[k] = cv; sub_i[k] = sv;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         ok = in_ready_o[k];
         @(posedge clk); #1;
         if (!ok && ($urandom_range(0, 1) == 1)) out_ready_i[k] = 1'b1;
      end
      in_valid_i[k] = 1'b0;
      a_i[k] = $urandom; b_i[k] = $urandom;
      cin_i[k] = 1'($urandom_range(0, 1)); sub_i[k] = 1'($urandom_range(0, 1));
      if (!ok) check("accept_timeout", k, 32'd0, 32'd1);
   endtask

   task automatic drain(input int k);
      out_ready_i[k] = 1'b1;
      for (int t = 0; t < 100 && busy[k]; t++) begin
         @(posedge clk); #1;
      end
      if (busy[k]) check("drain_timeout", k, 32'd1, 32'd0);
   endtask

   task automatic wait_valid(input int k);
      bit seen;
      seen = 1'b0;
      for (int t = 0; t < 100 && !seen; t++) begin
         @(posedge clk); #1;
         seen = out_valid_o[k];
      end
      if (!seen) check("valid_timeout", k, 32'd0, 32'd1);
   endtask

   task automatic rand_stream(input int k, input int n);
      for (int i = 0; i < n; i++) begin
         out_ready_i[k] = ($urandom_range(0, 3) != 0);
         do_op(k, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      drain(k);
   endtask

   initial begin
      res_t r;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid_i[k] = 1'b0; out_ready_i[k] = 1'b1;
         a_i[k] = '0; b_i[k] = '0; cin_i[k] = 1'b0; sub_i[k] = 1'b0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check("rst_sum", k, sum_o[k], 32'd0);
         check("rst_cout", k, 32'(cout_o[k]), 32'd0);
         check("rst_ovf", k, 32'(ovf_o[k]), 32'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;

      // Hand-computed values pinning the reference model.
      r = ref_calc(8, 32'h3C, 32'h0F, 1'b0, 1'b0);
      check("pin_3c_0f", 0, {r.sum[7:0], 7'd0, r.cout, 7'd0, r.ovf}, {8'h4B, 8'h00, 8'h00});
      r = ref_calc(8, 32'hFF, 32'h01, 1'b0, 1'b0);
      check("pin_ff_01", 0, {r.sum[7:0], 7'd0, r.cout, 7'd0, r.ovf}, {8'h00, 8'h01, 8'h00});
      r = ref_calc(8, 32'h7F, 32'h01, 1'b0, 1'b0);
      check("pin_7f_01", 0, {r.sum[7:0], 7'd0, r.cout, 7'd0, r.ovf}, {8'h80, 8'h00, 8'h01});
      r = ref_calc(8, 32'h05, 32'h07, 1'b0, 1'b1);
      check("pin_05_m07", 0, {r.sum[7:0], 7'd0, r.cout, 7'd0, r.ovf}, {8'hFE, 8'h00, 8'h00});
      r = ref_calc(8, 32'h80, 32'h01, 1'b0, 1'b1);
      check("pin_80_m01", 0, {r.sum[7:0], 7'd0, r.cout, 7'd0, r.ovf}, {8'h7F, 8'h01, 8'h01});
      r = ref_calc(32, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
      check("pin32_sub", 2, {r.sum, 7'd0, r.cout, 7'd0, r.ovf}, {32'h7FFF_FFFE, 8'h01, 8'h01});

      // Directed cases on the 8/4 instance.
      do_op(0, 32'h3C, 32'h0F, 1'b0, 1'b0); drain(0);
      do_op(0, 32'hFF, 32'h01, 1'b0, 1'b0); drain(0);
      do_op(0, 32'h7F, 32'h01, 1'b0, 1'b0); drain(0);
      do_op(0, 32'h05, 32'h07, 1'b0, 1'b1); drain(0);
      do_op(0, 32'h80, 32'h01, 1'b0, 1'b1); drain(0);

      // Backpressure, then back-to-back accept in the release cycle.
      out_ready_i[0] = 1'b0;
      do_op(0, 32'h11, 32'h22, 1'b1, 1'b0);
      wait_valid(0);
      repeat (5) @(posedge clk);
      #1;
      out_ready_i[0] = 1'b1;
      do_op(0, 32'h40, 32'h05, 1'b1, 1'b1);
      drain(0);

      // Reset in the middle of RUN.
      do_op(0, 32'h12, 32'h34, 1'b0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrun_sum", 0, sum_o[0], 32'd0);
      check("midrun_valid", 0, 32'(out_valid_o[0]), 32'd0);
      @(posedge clk); #1;
      do_op(0, 32'h10, 32'h20, 1'b0, 1'b0); drain(0);

      // Reset while a result is held.
      out_ready_i[0] = 1'b0;
      do_op(0, 32'h55, 32'h66, 1'b0, 1'b0);
      wait_valid(0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready_i[0] = 1'b1;
      @(negedge clk);
      check("done_rst_valid", 0, 32'(out_valid_o[0]), 32'd0);
      @(posedge clk); #1;

      fork
         rand_stream(0, 40);
         rand_stream(1, 60);
         rand_stream(2, 25);
      join

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
